la_nor_pipe: RTL

- Parametrised, pipelined N-input, W-bit-wide bitwise NOR/OR reduction with a valid/ready handshake.
- It is the clocked, flow-controlled successor to the stdlib 2-input NOR cell.
- It is used where wide reductions such as flag merging, all-zero detection and error-summary collection must be registered and must tolerate downstream backpressure.
- It sits in the stdlib alongside the combinational gates and is built from plain RTL.

---
 rtl/la_nor_pipe.sv | 101 ++++++++++
 1 files changed

// File: rtl/la_nor_pipe.sv
// Pipelined N-operand, W-bit bitwise NOR/OR reduction with a valid/ready handshake.
// Latency: STAGES cycles from the accepting cycle to out_valid. Throughput is 1/cycle.
// Backpressure: per-stage advance chain; bubbles collapse; in_ready=0 only when full and out_ready=0.
//
// Ports:
//   clk, reset             rising-edge clock, asynchronous active-high reset
//   in_valid/in_ready      input handshake; in_data holds N operands of W bits, in_mode 0=NOR 1=OR
//   out_valid/out_ready    output handshake; out_data is the W-bit result
//   busy                   at least one pipeline stage holds a result
module la_nor_pipe #(
    parameter     PROP   = "DEFAULT",
    parameter int N      = 4,
    parameter int W      = 8,
    parameter int STAGES = 2
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [N*W-1:0] in_data,
    input  logic           in_mode,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [W-1:0]   out_data,
    output logic           busy
);

    // PROP only tags the instance for implementation tooling.
    logic unused_prop;
    assign unused_prop = |PROP;

    logic [STAGES-1:0] v_q;
    logic [STAGES-1:0] v_d;
    logic [STAGES-1:0] adv;
    logic [W-1:0]      d_q [STAGES];
    logic [W-1:0]      d_d [STAGES];
    logic [W-1:0]      red_or;
    logic [W-1:0]      stage0_dat;

    // Full reduction across all operands, then mode adjust, all before stage 0.
    always_comb begin
        red_or = '0;
        for (int i = 0; i < N; i++) begin
            red_or = red_or | in_data[i*W +: W];
        end
        stage0_dat = in_mode ? red_or : ~red_or;
    end

    // Advance chain evaluated from the output backward: a stage may load if it
    // is empty or the stage after it is moving this cycle.
    always_comb begin
        adv = '0;
        adv[STAGES-1] = ~v_q[STAGES-1] | out_ready;
        for (int k = STAGES - 2; k >= 0; k--) begin
            adv[k] = ~v_q[k] | adv[k+1];
        end
    end

    // Data registers only capture alongside a valid bit, so empty slots keep
    // their old (reset-clean) contents and never pick up undriven input data.
    always_comb begin
        v_d = v_q;
        for (int k = 0; k < STAGES; k++) begin
            d_d[k] = d_q[k];
        end
        if (adv[0]) begin
            v_d[0] = in_valid;
            if (in_valid) begin
                d_d[0] = stage0_dat;
            end
        end
        for (int k = 1; k < STAGES; k++) begin
            if (adv[k]) begin
                v_d[k] = v_q[k-1];
                if (v_q[k-1]) begin
                    d_d[k] = d_q[k-1];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            v_q <= '0;
            for (int k = 0; k < STAGES; k++) begin
                d_q[k] <= '0;
            end
        end else begin
            v_q <= v_d;
            for (int k = 0; k < STAGES; k++) begin
                d_q[k] <= d_d[k];
            end
        end
    end

    assign in_ready  = adv[0];
    assign out_valid = v_q[STAGES-1];
    assign out_data  = d_q[STAGES-1];
    assign busy      = |v_q;

endmodule
